// File: rtl/hub75_pkg.sv
// Shared types and defaults for the HUB75 line receiver.
package hub75_pkg;

  localparam int COLS_DEFAULT     = 32;
  localparam int ROW_BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TOP  = 2'd1,
    ST_BOT  = 2'd2
  } drain_state_e;

  // One shifted column: upper-half {r,g,b} and lower-half {r,g,b}.
  typedef struct packed {
    logic [2:0] hi;
    logic [2:0] lo;
  } pix_pair_t;

  function automatic pix_pair_t make_pair(input logic [1:0] r,
                                          input logic [1:0] g,
                                          input logic [1:0] b);
    pix_pair_t p;
    p.hi = {r[1], g[1], b[1]};
    p.lo = {r[0], g[0], b[0]};
    return p;
  endfunction

endpackage

// File: rtl/hub75_sync.sv
// Two-flop synchronizer for all panel inputs, plus a third stage for rise
// detection on the shift clock (bit W-2) and latch (bit W-1).
module hub75_sync
  import hub75_pkg::*;
#(
  parameter int W = ROW_BITS_DEFAULT + 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] bits_i,
  output logic [W-3:0] data_o,
  output logic         clk_rise_o,
  output logic         lat_rise_o
);

  logic [W-1:0] s1_q, s2_q, s3_q;
  logic         clk_rise_q, lat_rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      clk_rise_q <= 1'b0;
      lat_rise_q <= 1'b0;
    end else begin
      s1_q       <= bits_i;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      clk_rise_q <= s2_q[W-2] & ~s3_q[W-2];
      lat_rise_q <= s2_q[W-1] & ~s3_q[W-1];
    end
  end

  // Stage 3 data lines up with the registered rise pulses.
  assign data_o     = s3_q[W-3:0];
  assign clk_rise_o = clk_rise_q;
  assign lat_rise_o = lat_rise_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-bus receiver: captures shifted columns, snapshots them on latch
// and drains the line as top-half then bottom-half pixels over a valid/ready port.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLS     = COLS_DEFAULT,
  parameter int ROW_BITS = ROW_BITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mat_r,
  input  logic [1:0]              mat_g,
  input  logic [1:0]              mat_b,
  input  logic [ROW_BITS-1:0]     mat_row,
  input  logic                    mat_clk,
  input  logic                    mat_lat,
  input  logic                    mat_oe,
  output logic                    px_valid,
  input  logic                    px_ready,
  output logic [$clog2(COLS)-1:0] px_x,
  output logic [ROW_BITS:0]       px_y,
  output logic [2:0]              px_rgb,
  output logic                    line_done,
  output logic                    err_len,
  output logic                    err_ovr,
  output logic [15:0]             oe_cycles
);

  localparam int XW     = $clog2(COLS);
  localparam int CW     = $clog2(COLS + 2);
  localparam int DW     = 7 + ROW_BITS;
  localparam int SW     = DW + 2;
  localparam int OE_BIT = 6 + ROW_BITS;
  localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(COLS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(COLS + 1);

  logic [SW-1:0]       raw_bits;
  logic [DW-1:0]       syn_bits;
  logic                clk_rise, lat_rise;
  pix_pair_t           col_in;
  logic [ROW_BITS-1:0] row_in;
  logic                oe_n;

  assign raw_bits = {mat_lat, mat_clk, mat_oe, mat_row, mat_b, mat_g, mat_r};

  hub75_sync #(.W(SW)) u_sync (
    .clk_i      (clk),
    .rst_ni     (rst),
    .bits_i     (raw_bits),
    .data_o     (syn_bits),
    .clk_rise_o (clk_rise),
    .lat_rise_o (lat_rise)
  );

  assign col_in = make_pair(syn_bits[1:0], syn_bits[3:2], syn_bits[5:4]);
  assign row_in = syn_bits[6 +: ROW_BITS];
  assign oe_n   = syn_bits[OE_BIT];

  pix_pair_t [COLS-1:0] shift_q, shift_d, snap_q;
  logic [CW-1:0]        col_q, col_sh, col_d;
  logic [ROW_BITS-1:0]  row_q;
  logic                 err_len_q, err_ovr_q;
  logic [15:0]          oe_cnt_q, oe_cycles_q;

  drain_state_e         state_q, state_d;
  logic [XW-1:0]        x_q, x_d;
  logic                 vld_q, vld_d;
  logic [XW-1:0]        px_x_q, px_x_d;
  logic [ROW_BITS:0]    px_y_q, px_y_d;
  logic [2:0]           rgb_q, rgb_d;
  logic                 last_q, last_d;
  logic                 line_done_q, line_done_d;
  logic                 load;

  // Shift happens before the latch sees the count, so a same-cycle column is kept.
  always_comb begin
    shift_d = shift_q;
    col_sh  = col_q;
    if (clk_rise) begin
      shift_d = {shift_q[COLS-2:0], col_in};
      if (col_q != CNT_SAT) col_sh = col_q + 1'b1;
    end
    col_d = lat_rise ? '0 : col_sh;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q     <= '0;
      snap_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      err_len_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
      oe_cnt_q    <= '0;
      oe_cycles_q <= '0;
    end else begin
      shift_q <= shift_d;
      col_q   <= col_d;
      if (lat_rise) begin
        snap_q      <= shift_d;
        row_q       <= row_in;
        oe_cycles_q <= oe_cnt_q;
        oe_cnt_q    <= '0;
        if (col_sh != CNT_FULL) err_len_q <= 1'b1;
        if (state_q != ST_IDLE || vld_q) err_ovr_q <= 1'b1;
      end else if (!oe_n && oe_cnt_q != 16'hFFFF) begin
        oe_cnt_q <= oe_cnt_q + 1'b1;
      end
    end
  end

  // The FSM walks x over the snapshot; the output register is a one-deep
  // stage refilled whenever it is empty or being accepted.
  assign load = ~vld_q | px_ready;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    vld_d       = vld_q;
    px_x_d      = px_x_q;
    px_y_d      = px_y_q;
    rgb_d       = rgb_q;
    last_d      = last_q;
    line_done_d = vld_q & px_ready & last_q;
    if (lat_rise) begin
      state_d = ST_TOP;
      x_d     = '0;
      vld_d   = 1'b0;
      last_d  = 1'b0;
    end else if (load) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
      if (state_q != ST_IDLE) begin
        vld_d  = 1'b1;
        px_x_d = x_q;
        px_y_d = {state_q == ST_BOT, row_q};
        rgb_d  = (state_q == ST_BOT) ? snap_q[x_q].lo : snap_q[x_q].hi;
        last_d = (state_q == ST_BOT) && (x_q == X_LAST);
        x_d    = x_q + 1'b1;
        if (x_q == X_LAST) state_d = (state_q == ST_TOP) ? ST_BOT : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      vld_q       <= 1'b0;
      px_x_q      <= '0;
      px_y_q      <= '0;
      rgb_q       <= '0;
      last_q      <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      vld_q       <= vld_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
      rgb_q       <= rgb_d;
      last_q      <= last_d;
      line_done_q <= line_done_d;
    end
  end

  assign px_valid  = vld_q;
  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign px_rgb    = rgb_q;
  assign line_done = line_done_q;
  assign err_len   = err_len_q;
  assign err_ovr   = err_ovr_q;
  assign oe_cycles = oe_cycles_q;

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 Parameter COLS, default 32, panel columns per chained row; power of two, 8..64.
REQ-002 Parameter ROW_BITS, default 4, width of the row-address bus; half-panel height is 2**ROW_BITS.
REQ-003 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1, asynchronous, active-low reset.
REQ-005 Port mat_r, input, 2, red data; bit 1 is the upper half, bit 0 the lower half.
REQ-006 Port mat_g, input, 2, green data, same bit mapping as mat_r.
REQ-007 Port mat_b, input, 2, blue data, same bit mapping as mat_r.
REQ-008 Port mat_row, input, ROW_BITS, row address.
REQ-009 Port mat_clk, input, 1, shift clock; a rising edge shifts in one column.
REQ-010 Port mat_lat, input, 1, latch; a rising edge commits the line.
REQ-011 Port mat_oe, input, 1, output enable, active-low.
REQ-012 Port px_valid, output, 1, pixel write valid.
REQ-013 Port px_ready, input, 1, pixel sink ready.
REQ-014 Port px_x, output, log2(COLS), pixel column.
REQ-015 Port px_y, output, ROW_BITS+1, pixel row.
REQ-016 Port px_rgb, output, 3, pixel colour {r,g,b}.
REQ-017 Port line_done, output, 1, one-cycle pulse after the last pixel of a line.
REQ-018 Port err_len, output, 1, sticky flag: column count at latch was not COLS.
REQ-019 Port err_ovr, output, 1, sticky flag: a latch arrived while a drain was in progress.
REQ-020 Port oe_cycles, output, 16, count of clk cycles mat_oe was low during the previous line period, saturating at 0xFFFF.

Function
REQ-021 Every mat_* input SHALL pass through a 2-flop synchronizer; edges SHALL be detected from the 2nd and 3rd flop stages.
REQ-022 A mat_clk rising edge SHALL shift the 6 data bits into a COLS-entry shift register; the newest entry is x=0, and entry k holds the data shifted in k edges earlier.
REQ-023 Shifting SHALL update a column counter that saturates at COLS+1; extra edges discard the oldest entry, as a real panel chain does.
REQ-024 A mat_lat rising edge SHALL, in the same cycle:
- copy the shift register into a snapshot buffer;
- capture mat_row as line_row;
- set err_len if the column count is not COLS;
- clear the column counter;
- latch the oe low-cycle count into oe_cycles and restart that count.
REQ-025 The drain FSM SHALL have states IDLE, TOP and BOT; a latch edge moves the FSM to TOP with x=0.
REQ-026 In TOP, pixels SHALL be px_y={0,line_row} with upper-half data, x ascending; after x=COLS-1 is accepted the FSM SHALL go to BOT.
REQ-027 In BOT, pixels SHALL be px_y={1,line_row} with lower-half data; after x=COLS-1 is accepted the FSM SHALL return to IDLE and pulse line_done in that same cycle.
REQ-028 A pixel transfer SHALL occur only when px_valid and px_ready are both high; px_x, px_y and px_rgb SHALL hold stable while px_valid is high and px_ready is low.
REQ-029 px_valid SHALL first go high on the 4th clk rising edge after the edge that first samples mat_lat high.
REQ-030 A latch edge in TOP or BOT SHALL set err_ovr, abort the current drain and restart in TOP with the new snapshot; no pixel of the aborted line is emitted after the restart.
REQ-031 A mat_clk edge and a mat_lat edge detected in the same cycle SHALL shift first, so the new column is included in the snapshot.
REQ-032 mat_clk edges during a drain SHALL keep shifting into the shift register only; the snapshot SHALL NOT change.
REQ-033 err_len and err_ovr SHALL clear only on reset.

Reset
REQ-034 While rst is low, all of the following SHALL be 0: px_valid, px_x, px_y, px_rgb, line_done, err_len, err_ovr, oe_cycles, the synchronizers, counters and buffers; the FSM SHALL be IDLE.
REQ-035 Reset asserted mid-drain SHALL abort the drain immediately; no further pixels are emitted until a new latch edge after reset release.

Structure
REQ-036 The shared package hub75_pkg SHALL hold COLS_DEFAULT, ROW_BITS_DEFAULT, the FSM state enum and the 6-bit pixel-pair type.
REQ-037 Synchronization and edge detection SHALL be a separate sub-module, hub75_sync, instantiated once for the 13 mat_* bits and providing clk/lat rise pulses.

Verification
REQ-038 Reset, 32 mat_clk pulses with column i data r=1 only for i=0, lat with row 5 -> 64 pixels; (x=31,y=5) rgb=100; all other pixels 000; line_done once; err_len=0.
REQ-039 30 pulses then lat -> err_len=1 and 64 pixels still emitted; x=30,31 carry pre-reset zero data.
REQ-040 px_ready held low for 10 cycles mid-TOP -> px_x/px_y/px_rgb stable throughout; no pixel lost or duplicated.
REQ-041 Second lat 20 pixels into a drain -> err_ovr=1; drain restarts at x=0 with new row; 64 pixels follow.
REQ-042 mat_oe low for 100 clk cycles between two latches -> oe_cycles=100 (+/-1 for sync) after the second latch.
REQ-043 rst pulsed low mid-BOT -> px_valid=0 within one cycle and all outputs 0; next full line is drained correctly.
